// File: rtl/ram_arbiter.sv
// Two-requester arbiter in front of a single-port RAM with a registered read port.
// After reset an optional sweep clears every RAM word before requests are accepted.
module ram_arbiter #(
   parameter int abits    = 12,
   parameter int dbits    = 64,
   parameter int init_ena = 1
) (
   input  logic             i_clk,
   input  logic             i_rst,
   output logic             o_ready,
   input  logic             i_req0,
   input  logic             i_req1,
   input  logic             i_we0,
   input  logic             i_we1,
   input  logic [abits-1:0] i_addr0,
   input  logic [abits-1:0] i_addr1,
   input  logic [dbits-1:0] i_wdata0,
   input  logic [dbits-1:0] i_wdata1,
   output logic             o_gnt0,
   output logic             o_gnt1,
   output logic             o_rvalid0,
   output logic             o_rvalid1,
   output logic [dbits-1:0] o_rdata0,
   output logic [dbits-1:0] o_rdata1,
   output logic [abits-1:0] o_ram_addr,
   output logic             o_ram_wena,
   output logic [dbits-1:0] o_ram_wdata,
   input  logic [dbits-1:0] i_ram_rdata
);

   typedef enum logic {ST_INIT, ST_RUN} state_t;

   localparam state_t RESET_STATE = (init_ena != 0) ? ST_INIT : ST_RUN;

   state_t           state_q, state_d;
   logic [abits-1:0] cnt_q, cnt_d;
   logic             last_q, last_d;
   logic             rvalid0_q, rvalid0_d;
   logic             rvalid1_q, rvalid1_d;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q   <= RESET_STATE;
         cnt_q     <= '0;
         last_q    <= 1'b1;
         rvalid0_q <= 1'b0;
         rvalid1_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         last_q    <= last_d;
         rvalid0_q <= rvalid0_d;
         rvalid1_q <= rvalid1_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      last_d      = last_q;
      o_ready     = 1'b0;
      o_gnt0      = 1'b0;
      o_gnt1      = 1'b0;
      o_ram_addr  = i_addr0;
      o_ram_wdata = i_wdata0;
      o_ram_wena  = 1'b0;

      // Everything that reaches the RAM or the requesters is held off while reset is high.
      if (!i_rst) begin
         case (state_q)
            ST_INIT: begin
               o_ram_wena  = 1'b1;
               o_ram_addr  = cnt_q;
               o_ram_wdata = '0;
               cnt_d       = cnt_q + 1'b1;
               if (cnt_q == '1) begin
                  state_d = ST_RUN;
               end
            end
            ST_RUN: begin
               o_ready = 1'b1;
               // On contention the requester that was not granted last time wins.
               if (i_req0 && (!i_req1 || last_q)) begin
                  o_gnt0     = 1'b1;
                  o_ram_wena = i_we0;
                  last_d     = 1'b0;
               end else if (i_req1) begin
                  o_gnt1      = 1'b1;
                  o_ram_addr  = i_addr1;
                  o_ram_wdata = i_wdata1;
                  o_ram_wena  = i_we1;
                  last_d      = 1'b1;
               end
            end
            default: begin
               state_d = RESET_STATE;
            end
         endcase
      end

      rvalid0_d = o_gnt0 & ~i_we0;
      rvalid1_d = o_gnt1 & ~i_we1;
   end

   assign o_rvalid0 = rvalid0_q & ~i_rst;
   assign o_rvalid1 = rvalid1_q & ~i_rst;
   assign o_rdata0  = i_ram_rdata;
   assign o_rdata1  = i_ram_rdata;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: a small RAM model plus a behavioural model of grants,
// memory contents and pending read responses, driven by randomized requests.
module tb_ram_arbiter;

   localparam int A = 4;
   localparam int D = 16;
   localparam int N = 1 << A;

   logic         clk = 1'b0;
   logic         rst;
   logic         req0, req1, we0, we1;
   logic [A-1:0] addr0, addr1;
   logic [D-1:0] wdata0, wdata1;
   logic         ready, gnt0, gnt1, rvalid0, rvalid1;
   logic [D-1:0] rdata0, rdata1;
   logic [A-1:0] ram_addr;
   logic         ram_wena;
   logic [D-1:0] ram_wdata, ram_rdata;
   logic [D-1:0] ram_mem [N];

   int total = 0;
   int bad   = 0;

   logic         m_last;
   logic [D-1:0] m_mem [N];
   logic         m_rv0, m_rv1;
   logic [D-1:0] m_rd0, m_rd1;
   logic         e_g0, e_g1, e_wena;
   logic [A-1:0] e_addr;
   logic [D-1:0] e_wdata;

   ram_arbiter #(.abits(A), .dbits(D), .init_ena(1)) dut (
      .i_clk(clk), .i_rst(rst), .o_ready(ready),
      .i_req0(req0), .i_req1(req1), .i_we0(we0), .i_we1(we1),
      .i_addr0(addr0), .i_addr1(addr1), .i_wdata0(wdata0), .i_wdata1(wdata1),
      .o_gnt0(gnt0), .o_gnt1(gnt1), .o_rvalid0(rvalid0), .o_rvalid1(rvalid1),
      .o_rdata0(rdata0), .o_rdata1(rdata1),
      .o_ram_addr(ram_addr), .o_ram_wena(ram_wena), .o_ram_wdata(ram_wdata),
      .i_ram_rdata(ram_rdata)
   );

   always #5 clk = ~clk;

   // Single-port RAM with a registered read, preloaded with junk so the clearing sweep is visible.
   initial begin
      for (int i = 0; i < N; i++) ram_mem[i] = D'($urandom);
   end

   always @(posedge clk) begin
      if (ram_wena) ram_mem[ram_addr] <= ram_wdata;
      ram_rdata <= ram_mem[ram_addr];
   end

   task automatic model_reset();
      m_last = 1'b1;
      m_rv0  = 1'b0;
      m_rv1  = 1'b0;
      for (int i = 0; i < N; i++) m_mem[i] = '0;
   endtask

   task automatic model_eval();
      e_g0    = req0 && (!req1 || m_last);
      e_g1    = req1 && !e_g0;
      e_wena  = (e_g0 && we0) || (e_g1 && we1);
      e_addr  = e_g1 ? addr1 : addr0;
      e_wdata = e_g1 ? wdata1 : wdata0;
   endtask

   task automatic model_commit();
      m_rv0 = e_g0 && !we0;
      m_rd0 = m_mem[addr0];
      m_rv1 = e_g1 && !we1;
      m_rd1 = m_mem[addr1];
      if (e_wena) m_mem[e_addr] = e_wdata;
      if (e_g0) m_last = 1'b0;
      else if (e_g1) m_last = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1; req0 = 1'b1; req1 = 1'b1; we0 = 1'b1; we1 = 1'b0;
      addr0 = '0; addr1 = '0; wdata0 = '1; wdata1 = '1;
      for (int i = 0; i < 3; i++) begin
         #1;
         total++; if (ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%0b exp=0", ready); end
         total++; if (gnt0 !== 1'b0) begin bad++; $display("FAIL rst_gnt0 got=%0b exp=0", gnt0); end
         total++; if (gnt1 !== 1'b0) begin bad++; $display("FAIL rst_gnt1 got=%0b exp=0", gnt1); end
         total++; if (ram_wena !== 1'b0) begin bad++; $display("FAIL rst_wena got=%0b exp=0", ram_wena); end
         total++; if ({rvalid0, rvalid1} !== 2'b00) begin bad++; $display("FAIL rst_rvalid got=%0b%0b exp=00", rvalid0, rvalid1); end
         @(negedge clk);
      end
   endtask

   // Releases reset (applied in the previous cycle) and follows the clearing sweep to RUN.
   task automatic test_init_sweep();
      rst = 1'b0; req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
      for (int k = 0; k < N; k++) begin
         #1;
         total++; if (ready !== 1'b0) begin bad++; $display("FAIL init_ready k=%0d got=%0b exp=0", k, ready); end
         total++; if ({gnt0, gnt1} !== 2'b00) begin bad++; $display("FAIL init_gnt k=%0d got=%0b%0b exp=00", k, gnt0, gnt1); end
         total++; if (ram_wena !== 1'b1) begin bad++; $display("FAIL init_wena k=%0d got=%0b exp=1", k, ram_wena); end
         total++; if (ram_addr !== A'(k)) begin bad++; $display("FAIL init_addr got=%0d exp=%0d", ram_addr, k); end
         total++; if (ram_wdata !== '0) begin bad++; $display("FAIL init_wdata k=%0d got=%0h exp=0", k, ram_wdata); end
         total++; if ({rvalid0, rvalid1} !== 2'b00) begin bad++; $display("FAIL init_rvalid k=%0d got=%0b%0b exp=00", k, rvalid0, rvalid1); end
         @(negedge clk);
      end
      req0 = 1'b0; req1 = 1'b0;
      #1;
      total++; if (ready !== 1'b1) begin bad++; $display("FAIL init_done_ready got=%0b exp=1", ready); end
      total++; if (ram_wena !== 1'b0) begin bad++; $display("FAIL init_done_wena got=%0b exp=0", ram_wena); end
      model_reset();
      @(negedge clk);
   endtask

   task automatic test_alternate();
      req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
      addr0 = A'($urandom); addr1 = A'($urandom);
      for (int i = 0; i < 9; i++) begin
         if (i == 8) begin req0 = 1'b0; req1 = 1'b0; end
         #1;
         model_eval();
         if (i < 8) begin
            total++; if (gnt0 !== 1'(i % 2 == 0)) begin bad++; $display("FAIL alt_gnt0 i=%0d got=%0b exp=%0b", i, gnt0, i % 2 == 0); end
            total++; if (gnt1 !== e_g1) begin bad++; $display("FAIL alt_gnt1 i=%0d got=%0b exp=%0b", i, gnt1, e_g1); end
         end
         total++; if (rvalid0 !== m_rv0) begin bad++; $display("FAIL alt_rvalid0 i=%0d got=%0b exp=%0b", i, rvalid0, m_rv0); end
         total++; if (rvalid1 !== m_rv1) begin bad++; $display("FAIL alt_rvalid1 i=%0d got=%0b exp=%0b", i, rvalid1, m_rv1); end
         if (m_rv0) begin total++; if (rdata0 !== m_rd0) begin bad++; $display("FAIL alt_rdata0 got=%0h exp=%0h", rdata0, m_rd0); end end
         if (m_rv1) begin total++; if (rdata1 !== m_rd1) begin bad++; $display("FAIL alt_rdata1 got=%0h exp=%0h", rdata1, m_rd1); end end
         model_commit();
         @(negedge clk);
         if (e_g0) addr0 = A'($urandom);
         if (e_g1) addr1 = A'($urandom);
      end
   endtask

   task automatic test_read_all();
      req1 = 1'b0; we0 = 1'b0;
      for (int k = 0; k <= N; k++) begin
         req0 = (k < N);
         addr0 = A'(k);
         #1;
         model_eval();
         total++; if (gnt0 !== 1'(k < N)) begin bad++; $display("FAIL rdall_gnt0 k=%0d got=%0b exp=%0b", k, gnt0, k < N); end
         total++; if (rvalid0 !== 1'(k > 0)) begin bad++; $display("FAIL rdall_rvalid0 k=%0d got=%0b exp=%0b", k, rvalid0, k > 0); end
         total++; if (rvalid1 !== 1'b0) begin bad++; $display("FAIL rdall_rvalid1 k=%0d got=%0b exp=0", k, rvalid1); end
         if (k > 0) begin total++; if (rdata0 !== '0) begin bad++; $display("FAIL rdall_rdata0 addr=%0d got=%0h exp=0", k - 1, rdata0); end end
         model_commit();
         @(negedge clk);
      end
   endtask

   task automatic test_write_read();
      req0 = 1'b1; we0 = 1'b1; addr0 = A'(3); wdata0 = D'(16'h00A5); req1 = 1'b0;
      #1;
      model_eval();
      total++; if (gnt0 !== 1'b1) begin bad++; $display("FAIL wr_gnt0 got=%0b exp=1", gnt0); end
      total++; if (ram_wena !== 1'b1) begin bad++; $display("FAIL wr_wena got=%0b exp=1", ram_wena); end
      total++; if (ram_addr !== A'(3)) begin bad++; $display("FAIL wr_addr got=%0d exp=3", ram_addr); end
      total++; if (ram_wdata !== D'(16'h00A5)) begin bad++; $display("FAIL wr_wdata got=%0h exp=a5", ram_wdata); end
      model_commit();
      @(negedge clk);
      req0 = 1'b0; req1 = 1'b1; we1 = 1'b0; addr1 = A'(3);
      #1;
      model_eval();
      total++; if (gnt1 !== 1'b1) begin bad++; $display("FAIL rd_gnt1 got=%0b exp=1", gnt1); end
      total++; if (ram_wena !== 1'b0) begin bad++; $display("FAIL rd_wena got=%0b exp=0", ram_wena); end
      total++; if (rvalid0 !== 1'b0) begin bad++; $display("FAIL wr_no_rvalid got=%0b exp=0", rvalid0); end
      model_commit();
      @(negedge clk);
      req1 = 1'b0;
      #1;
      model_eval();
      total++; if (rvalid1 !== 1'b1) begin bad++; $display("FAIL rd_rvalid1 got=%0b exp=1", rvalid1); end
      total++; if (rdata1 !== D'(16'h00A5)) begin bad++; $display("FAIL rd_rdata1 got=%0h exp=a5", rdata1); end
      total++; if (rvalid0 !== 1'b0) begin bad++; $display("FAIL rd_rvalid0 got=%0b exp=0", rvalid0); end
      model_commit();
      @(negedge clk);
   endtask

   task automatic test_single_req1();
      req0 = 1'b0; we1 = 1'b0;
      for (int i = 0; i < 6; i++) begin
         req1 = (i < 5);
         addr1 = A'($urandom);
         #1;
         model_eval();
         total++; if (gnt1 !== 1'(i < 5)) begin bad++; $display("FAIL solo_gnt1 i=%0d got=%0b exp=%0b", i, gnt1, i < 5); end
         total++; if (gnt0 !== 1'b0) begin bad++; $display("FAIL solo_gnt0 i=%0d got=%0b exp=0", i, gnt0); end
         total++; if (rvalid1 !== m_rv1) begin bad++; $display("FAIL solo_rvalid1 i=%0d got=%0b exp=%0b", i, rvalid1, m_rv1); end
         if (m_rv1) begin total++; if (rdata1 !== m_rd1) begin bad++; $display("FAIL solo_rdata1 got=%0h exp=%0h", rdata1, m_rd1); end end
         model_commit();
         @(negedge clk);
      end
   endtask

   // Each requester holds its request until granted, then may issue a fresh random one.
   task automatic test_random();
      logic act0 = 1'b0;
      logic act1 = 1'b0;
      for (int i = 0; i <= 300; i++) begin
         if (!act0) begin
            act0 = (i < 300) && ($urandom_range(0, 3) != 0);
            we0 = 1'($urandom); addr0 = A'($urandom); wdata0 = D'($urandom);
         end
         if (!act1) begin
            act1 = (i < 300) && ($urandom_range(0, 3) != 0);
            we1 = 1'($urandom); addr1 = A'($urandom); wdata1 = D'($urandom);
         end
         req0 = act0; req1 = act1;
         #1;
         model_eval();
         total++; if (ready !== 1'b1) begin bad++; $display("FAIL rnd_ready i=%0d got=%0b exp=1", i, ready); end
         total++; if ((gnt0 & gnt1) !== 1'b0) begin bad++; $display("FAIL rnd_both_gnt i=%0d got=1 exp=0", i); end
         total++; if (gnt0 !== e_g0) begin bad++; $display("FAIL rnd_gnt0 i=%0d got=%0b exp=%0b", i, gnt0, e_g0); end
         total++; if (gnt1 !== e_g1) begin bad++; $display("FAIL rnd_gnt1 i=%0d got=%0b exp=%0b", i, gnt1, e_g1); end
         total++; if (ram_wena !== e_wena) begin bad++; $display("FAIL rnd_wena i=%0d got=%0b exp=%0b", i, ram_wena, e_wena); end
         total++; if (ram_addr !== e_addr) begin bad++; $display("FAIL rnd_addr i=%0d got=%0h exp=%0h", i, ram_addr, e_addr); end
         total++; if (ram_wdata !== e_wdata) begin bad++; $display("FAIL rnd_wdata i=%0d got=%0h exp=%0h", i, ram_wdata, e_wdata); end
         total++; if (rvalid0 !== m_rv0) begin bad++; $display("FAIL rnd_rvalid0 i=%0d got=%0b exp=%0b", i, rvalid0, m_rv0); end
         total++; if (rvalid1 !== m_rv1) begin bad++; $display("FAIL rnd_rvalid1 i=%0d got=%0b exp=%0b", i, rvalid1, m_rv1); end
         if (m_rv0) begin total++; if (rdata0 !== m_rd0) begin bad++; $display("FAIL rnd_rdata0 i=%0d got=%0h exp=%0h", i, rdata0, m_rd0); end end
         if (m_rv1) begin total++; if (rdata1 !== m_rd1) begin bad++; $display("FAIL rnd_rdata1 i=%0d got=%0h exp=%0h", i, rdata1, m_rd1); end end
         model_commit();
         @(negedge clk);
         if (e_g0) act0 = 1'b0;
         if (e_g1) act1 = 1'b0;
      end
      req0 = 1'b0; req1 = 1'b0;
   endtask

   task automatic test_reset_mid_init();
      rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 7; k++) begin
         #1;
         total++; if (ram_addr !== A'(k)) begin bad++; $display("FAIL mid_addr got=%0d exp=%0d", ram_addr, k); end
         @(negedge clk);
      end
      rst = 1'b1;
      #1;
      total++; if (ram_wena !== 1'b0) begin bad++; $display("FAIL mid_rst_wena got=%0b exp=0", ram_wena); end
      total++; if (ready !== 1'b0) begin bad++; $display("FAIL mid_rst_ready got=%0b exp=0", ready); end
      @(negedge clk);
      test_init_sweep();
      test_read_all();
   endtask

   task automatic test_reset_read();
      req0 = 1'b1; we0 = 1'b0; addr0 = A'(5); req1 = 1'b0;
      #1;
      total++; if (gnt0 !== 1'b1) begin bad++; $display("FAIL rstrd_gnt0 got=%0b exp=1", gnt0); end
      @(negedge clk);
      req0 = 1'b0; rst = 1'b1;
      #1;
      total++; if (rvalid0 !== 1'b0) begin bad++; $display("FAIL rstrd_rvalid0 got=%0b exp=0", rvalid0); end
      @(negedge clk);
      test_init_sweep();
   endtask

   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      @(negedge clk);
      test_reset();
      test_init_sweep();
      test_alternate();
      test_read_all();
      test_write_read();
      test_single_req1();
      test_random();
      test_reset_mid_init();
      test_reset_read();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
